// File: rtl/apu_dispatch.sv
// Purpose: issue one APU instruction at a time, read its operands, hand them to the APU and write the result back.
// Latency: at least 2 cycles from accept to writeback; the next instruction is accepted the cycle after writeback.
// Backpressure: instr_ready is low while an instruction is in flight; apu_req holds the operands until apu_gnt.
module apu_dispatch #(
    parameter int XLEN     = 32,
    parameter int APU_OP_W = 6,
    parameter int NFLAGS   = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [APU_OP_W-1:0] instr_op,
    input  logic [4:0]          instr_rs1,
    input  logic [4:0]          instr_rs2,
    input  logic [4:0]          instr_rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    input  logic [XLEN-1:0]     apu_operands_i_1,
    input  logic [XLEN-1:0]     apu_operands_i_2,
    output logic                apu_req,
    input  logic                apu_gnt,
    output logic [APU_OP_W-1:0] apu_op,
    output logic [XLEN-1:0]     apu_operand_a,
    output logic [XLEN-1:0]     apu_operand_b,
    input  logic                apu_rvalid,
    input  logic [XLEN-1:0]     apu_result,
    input  logic [NFLAGS-1:0]   apu_flags,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     rd_data,
    output logic                register_file_enable,
    output logic [NFLAGS-1:0]   fflags,
    input  logic                fflags_clear,
    output logic                timeout_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NFLAGS-1:0]  flags_q;
    logic               accept;
    logic               capture;
    logic               timeout_hit;

    // Register file read addresses follow decode directly so operands are ready at accept.
    assign rs1 = instr_rs1;
    assign rs2 = instr_rs2;

    assign instr_ready = (state == S_IDLE);
    assign apu_req     = (state == S_REQ);
    assign busy        = (state != S_IDLE);

    // Next-state logic; capture marks the cycle the APU result is taken.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (apu_gnt) begin
                    if (apu_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (apu_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = S_WB;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/op/destination latch at accept; result and flags latch when the APU responds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            apu_op        <= '0;
            apu_operand_a <= '0;
            apu_operand_b <= '0;
            rd            <= '0;
            rd_data       <= '0;
            flags_q       <= '0;
        end else begin
            if (accept) begin
                apu_op        <= instr_op;
                apu_operand_a <= apu_operands_i_1;
                apu_operand_b <= apu_operands_i_2;
                rd            <= instr_rd;
            end
            if (capture) begin
                rd_data <= apu_result;
                flags_q <= apu_flags;
            end
        end
    end

    // Writeback strobe is high for the single WB cycle, suppressed for x0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            register_file_enable <= 1'b0;
        end else begin
            register_file_enable <= capture && (rd != 5'd0);
        end
    end

    // WAIT cycle counter, restarted on every grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == S_REQ) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky flags: a clear coinciding with WB drops old flags but keeps the new ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fflags      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WB) begin
                fflags <= (fflags_clear ? '0 : fflags) | flags_q;
            end else if (fflags_clear) begin
                fflags <= '0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apu_dispatch.sv
module tb_apu_dispatch;

    localparam logic [5:0] OP_ADD = 6'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  instr_op = '0;
    logic [4:0]  instr_rs1 = '0;
    logic [4:0]  instr_rs2 = '0;
    logic [4:0]  instr_rd = '0;
    logic [4:0]  rs1, rs2;
    logic [31:0] apu_operands_i_1, apu_operands_i_2;
    logic        apu_req;
    logic        apu_gnt = 1'b0;
    logic [5:0]  apu_op;
    logic [31:0] apu_operand_a, apu_operand_b;
    logic        apu_rvalid = 1'b0;
    logic [31:0] apu_result = '0;
    logic [4:0]  apu_flags = '0;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        register_file_enable;
    logic [4:0]  fflags;
    logic        fflags_clear = 1'b0;
    logic        timeout_err;
    logic        busy;

    apu_dispatch dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
        .rs1(rs1), .rs2(rs2),
        .apu_operands_i_1(apu_operands_i_1), .apu_operands_i_2(apu_operands_i_2),
        .apu_req(apu_req), .apu_gnt(apu_gnt), .apu_op(apu_op),
        .apu_operand_a(apu_operand_a), .apu_operand_b(apu_operand_b),
        .apu_rvalid(apu_rvalid), .apu_result(apu_result), .apu_flags(apu_flags),
        .rd(rd), .rd_data(rd_data), .register_file_enable(register_file_enable),
        .fflags(fflags), .fflags_clear(fflags_clear),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Register file environment: combinational reads, writes on the negedge.
    logic [31:0] rf [32];
    logic        rf_load = 1'b1;
    assign apu_operands_i_1 = rf[rs1];
    assign apu_operands_i_2 = rf[rs2];

    always @(negedge clock) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 1) ? 32'd4 : (i == 2) ? 32'd7 : 32'd0;
        end else if (register_file_enable && rd != 5'd0) begin
            rf[rd] <= rd_data;
        end
    end

    // Behavioural model: architectural register values, expected APU requests and writebacks, sticky flags.
    logic [31:0] rf_model [32];
    logic [69:0] opq [$];
    logic [36:0] wbq [$];
    logic [4:0]  exp_fflags = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          en_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (reset && !rf_load) begin
            chk("ready_vs_busy", instr_ready, !busy);
            if (apu_req) begin
                if (opq.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    chk("apu_op", apu_op, opq[0][69:64]);
                    chk("apu_operand_a", apu_operand_a, opq[0][63:32]);
                    chk("apu_operand_b", apu_operand_b, opq[0][31:0]);
                    if (apu_gnt) void'(opq.pop_front());
                end
            end
            if (register_file_enable) begin
                en_cycles++;
                if (wbq.size() == 0) begin
                    chk("unexpected_writeback", 1, 0);
                end else begin
                    chk("wb_rd", rd, wbq[0][36:32]);
                    chk("wb_data", rd_data, wbq[0][31:0]);
                    void'(wbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction; rv = cycles from grant to rvalid (0 = same cycle, <0 = never).
    task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input int gd, input int rv,
                         input logic [31:0] res, input logic [4:0] fl, input logic clr);
        int n = 0;
        while (!instr_ready && n < 200) begin
            step();
            n++;
        end
        chk("issue_ready", instr_ready, 1);
        instr_valid = 1'b1; instr_op = op; instr_rs1 = s1; instr_rs2 = s2; instr_rd = d;
        opq.push_back({op, rf_model[s1], rf_model[s2]});
        step();
        instr_valid = 1'b0;
        repeat (gd) step();
        apu_gnt = 1'b1;
        if (rv == 0) begin
            apu_rvalid = 1'b1; apu_result = res; apu_flags = fl;
        end
        step();
        apu_gnt = 1'b0; apu_rvalid = 1'b0;
        if (rv > 0) begin
            repeat (rv - 1) step();
            apu_rvalid = 1'b1; apu_result = res; apu_flags = fl;
            step();
            apu_rvalid = 1'b0;
        end
        if (rv >= 0) begin
            if (d != 5'd0) begin
                wbq.push_back({d, res});
                rf_model[d] = res;
            end
            exp_fflags = (clr ? 5'd0 : exp_fflags) | fl;
            chk("wb_busy", busy, 1);
            chk("wb_enable", register_file_enable, d != 5'd0);
            fflags_clear = clr;
            step();
            fflags_clear = 1'b0;
            chk("wb_one_cycle", register_file_enable, 0);
            chk("idle_after_wb", instr_ready, 1);
            chk("fflags_model", fflags, exp_fflags);
        end
    endtask

    initial begin
        int n;
        int en0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        rf_model[1] = 32'd4;
        rf_model[2] = 32'd7;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", apu_req, 0);
        chk("rst_enable", register_file_enable, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_timeout", timeout_err, 0);
        rf_load = 1'b0;
        reset = 1'b1;
        step();

        // x3 = x1 + x2, grant in the first REQ cycle, result two cycles later.
        en0 = en_cycles;
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 0, 2, 32'd11, 5'b00000, 1'b0);
        chk("t1_rf_x3", rf[3], 32'd11);
        chk("t1_enable_cycles", en_cycles - en0, 1);

        // Grant and result together in the REQ cycle.
        issue(OP_ADD, 5'd1, 5'd3, 5'd5, 0, 0, 32'hDEAD, 5'b00001, 1'b0);
        chk("t2_fflags", fflags, 5'b00001);
        chk("t2_rf_x5", rf[5], 32'hDEAD);

        // rd = x0: no write, flags still accumulate.
        en0 = en_cycles;
        issue(OP_ADD, 5'd2, 5'd2, 5'd0, 1, 1, 32'h1234, 5'b10000, 1'b0);
        chk("t3_enable_cycles", en_cycles - en0, 0);
        chk("t3_fflags", fflags, 5'b10001);
        chk("t3_rf_x0", rf[0], 32'd0);

        // Clear in the WB cycle: only the new flags survive.
        issue(OP_ADD, 5'd1, 5'd1, 5'd6, 2, 3, 32'd8, 5'b00100, 1'b1);
        chk("t4_fflags", fflags, 5'b00100);

        // Timeout: grant, rvalid never arrives.
        en0 = en_cycles;
        issue(OP_ADD, 5'd1, 5'd2, 5'd7, 0, -1, 32'd0, 5'b00000, 1'b0);
        n = 1;
        while (busy && n < 200) begin
            chk("t5_no_timeout_yet", timeout_err, 0);
            step();
            n++;
        end
        chk("t5_wait_cycles", n, 65);
        chk("t5_timeout_err", timeout_err, 1);
        chk("t5_idle", instr_ready, 1);
        chk("t5_no_writeback", en_cycles - en0, 0);
        chk("t5_fflags", fflags, 5'b00100);

        // Reset in WAIT, then a late rvalid.
        issue(OP_ADD, 5'd1, 5'd2, 5'd8, 0, -1, 32'd0, 5'b00000, 1'b0);
        step();
        step();
        chk("t6_in_wait", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_ready", instr_ready, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_enable", register_file_enable, 0);
        chk("t6_rst_rd", rd, 0);
        chk("t6_rst_rd_data", rd_data, 0);
        chk("t6_rst_operand_a", apu_operand_a, 0);
        chk("t6_rst_fflags", fflags, 0);
        chk("t6_rst_timeout", timeout_err, 0);
        exp_fflags = 5'd0;
        step();
        reset = 1'b1;
        apu_rvalid = 1'b1; apu_result = 32'hBAD; apu_flags = 5'b11111;
        step();
        apu_rvalid = 1'b0;
        step();
        chk("t6_late_busy", busy, 0);
        chk("t6_late_fflags", fflags, 0);
        chk("t6_rf_x8", rf[8], 32'd0);

        // Back-to-back dependent instructions.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 0, 1, rf_model[1] + rf_model[2], 5'b00000, 1'b0);
        issue(OP_ADD, 5'd3, 5'd1, 5'd4, 0, 1, rf_model[3] + rf_model[1], 5'b00000, 1'b0);
        chk("t7_rf_x4", rf[4], 32'd15);
        chk("t7_model_x4", rf_model[4], 32'd15);

        step();
        chk("opq_empty", opq.size(), 0);
        chk("wbq_empty", wbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
